// File: rtl/secuenciador_datapath_pkg.sv
// Shared constants and state type for the multi-cycle datapath sequencer.
package secuenciador_datapath_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK
    } estado_t;

endpackage

// File: rtl/secuenciador_datapath_decodificador.sv
// Combinational opcode classifier: exactly one class flag is set for any op.
module decodificador_control
    import secuenciador_datapath_pkg::*;
(
    input  logic [5:0] op,
    output logic       es_rtype,
    output logic       es_lw,
    output logic       es_sw,
    output logic       es_beq,
    output logic       ilegal
);

    always_comb begin
        es_rtype = (op == OP_RTYPE);
        es_lw    = (op == OP_LW);
        es_sw    = (op == OP_SW);
        es_beq   = (op == OP_BEQ);
        ilegal   = ~(es_rtype | es_lw | es_sw | es_beq);
    end

endmodule

// File: rtl/secuenciador_datapath.sv
// Multi-cycle controller: accepts one instruction, then walks DECODE/EXECUTE/
// MEMORY/WRITEBACK so every register or memory write lands in a single cycle.
module secuenciador_datapath
    import secuenciador_datapath_pkg::*;
#(
    parameter int ANCHO_CONT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    input  logic                  zf,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [5:0]            funct,
    output logic [1:0]            alu_op,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  done,
    output logic                  branch_taken,
    output logic                  error,
    output logic [ANCHO_CONT-1:0] instr_count
);

    estado_t               estado_q, estado_d;
    logic [5:0]            op_q, op_d;
    logic [4:0]            rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]            funct_q, funct_d;
    logic [1:0]            alu_op_q, alu_op_d;
    logic                  error_q, error_d;
    logic [ANCHO_CONT-1:0] count_q, count_d;

    logic       es_rtype, es_lw, es_sw, es_beq, ilegal;
    logic [1:0] alu_sel;
    logic [4:0] destino;
    logic       unused_shamt;

    assign unused_shamt = ^instr[10:6];

    decodificador_control u_dec (
        .op       (op_q),
        .es_rtype (es_rtype),
        .es_lw    (es_lw),
        .es_sw    (es_sw),
        .es_beq   (es_beq),
        .ilegal   (ilegal)
    );

    always_comb begin
        alu_sel = es_rtype ? ALU_FUNCT : (es_beq ? ALU_SUB : ALU_ADD);
        destino = es_lw ? rt_q : rd_q;
    end

    always_comb begin
        estado_d     = estado_q;
        op_d         = op_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        funct_d      = funct_q;
        alu_op_d     = alu_op_q;
        error_d      = error_q;
        count_d      = count_q;
        instr_ready  = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        done         = 1'b0;
        branch_taken = 1'b0;
        alu_op       = alu_op_q;

        case (estado_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d     = instr[31:26];
                    rs_d     = instr[25:21];
                    rt_d     = instr[20:16];
                    rd_d     = instr[15:11];
                    funct_d  = instr[5:0];
                    estado_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ilegal) begin
                    error_d  = 1'b1;
                    done     = 1'b1;
                    estado_d = ST_IDLE;
                end else begin
                    estado_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                alu_op   = alu_sel;
                alu_op_d = alu_sel;
                if (es_beq) begin
                    done         = 1'b1;
                    branch_taken = zf;
                    estado_d     = ST_IDLE;
                end else if (es_rtype) begin
                    estado_d = ST_WRITEBACK;
                end else begin
                    estado_d = ST_MEMORY;
                end
            end
            ST_MEMORY: begin
                if (es_sw) begin
                    mem_write = 1'b1;
                    done      = 1'b1;
                    estado_d  = ST_IDLE;
                end else begin
                    estado_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                // Writes to register 0 are dropped but the instruction still retires.
                reg_write  = (destino != 5'd0);
                mem_to_reg = es_lw;
                done       = 1'b1;
                estado_d   = ST_IDLE;
            end
            default: estado_d = ST_IDLE;
        endcase

        if (done && (estado_q != ST_DECODE)) begin
            count_d = count_q + ANCHO_CONT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= ST_IDLE;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            funct_q  <= '0;
            alu_op_q <= '0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            funct_q  <= funct_d;
            alu_op_q <= alu_op_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    assign rs          = rs_q;
    assign rt          = rt_q;
    assign rd          = rd_q;
    assign funct       = funct_q;
    assign error       = error_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_secuenciador_datapath.sv
// Scoreboard bench: driver pushes predicted retirements, monitor checks each done.
module tb_secuenciador_datapath;

    localparam int ANCHO_CONT = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  instr_valid = 1'b0;
    logic [31:0]           instr = '0;
    logic                  instr_ready;
    logic                  zf = 1'b0;
    logic [4:0]            rs, rt, rd;
    logic [5:0]            funct;
    logic [1:0]            alu_op;
    logic                  reg_write, mem_write, mem_to_reg, done, branch_taken, error;
    logic [ANCHO_CONT-1:0] instr_count;

    secuenciador_datapath #(.ANCHO_CONT(ANCHO_CONT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .zf           (zf),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .funct        (funct),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .done         (done),
        .branch_taken (branch_taken),
        .error        (error),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              t;
        int              lat;
        logic            rw, mw, m2r, bt, err;
        logic [1:0]      alu;
        logic [4:0]      rs, rt, rd;
        logic [5:0]      funct;
        logic [ANCHO_CONT-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    // Reference model state: retired count, sticky error, last ALU operation
    logic [ANCHO_CONT-1:0] m_cnt = '0;
    logic                  m_err = 1'b0;
    logic [1:0]            m_alu = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic predict(input logic [31:0] w, input logic z, input int t, output exp_t e);
        logic [5:0] op;
        op      = w[31:26];
        e.t     = t;
        e.rs    = w[25:21];
        e.rt    = w[20:16];
        e.rd    = w[15:11];
        e.funct = w[5:0];
        e.cnt   = m_cnt;
        e.err   = m_err;
        e.rw = 0; e.mw = 0; e.m2r = 0; e.bt = 0;
        case (op)
            6'h00: begin e.lat = 3; e.alu = 2'b10; e.rw = (w[15:11] != 0); end
            6'h23: begin e.lat = 4; e.alu = 2'b00; e.rw = (w[20:16] != 0); e.m2r = 1; end
            6'h2B: begin e.lat = 3; e.alu = 2'b00; e.mw = 1; end
            6'h04: begin e.lat = 2; e.alu = 2'b01; e.bt = z; end
            default: begin e.lat = 1; e.alu = m_alu; end
        endcase
        if (e.lat == 1) m_err = 1'b1;
        else begin
            m_cnt = m_cnt + 1'b1;
            m_alu = e.alu;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done_queue", q.size(), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", cyc - e.t, e.lat);
                    check("reg_write", reg_write, e.rw);
                    check("mem_write", mem_write, e.mw);
                    check("mem_to_reg", mem_to_reg, e.m2r);
                    check("branch_taken", branch_taken, e.bt);
                    check("alu_op", alu_op, e.alu);
                    check("fields", {rs, rt, rd, funct}, {e.rs, e.rt, e.rd, e.funct});
                    check("count_at_done", instr_count, e.cnt);
                    check("error_at_done", error, e.err);
                end
            end else begin
                check("no_stray_ctrl", {reg_write, mem_write, mem_to_reg, branch_taken}, 4'b0000);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic z, input bit hold);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) begin
            check("ready_timeout", instr_ready, 1);
            return;
        end
        instr = w;
        zf = z;
        instr_valid = 1'b1;
        predict(w, z, cyc, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            instr_valid = 1'b0;
        end else begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!done && guard < 20);
            instr_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((q.size() != 0 || !instr_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue", q.size(), 0);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_ctrl", {instr_ready, reg_write, mem_write, mem_to_reg, done, branch_taken, error},
              7'b1000000);
        check("rst_fields", {rs, rt, rd, funct, alu_op}, 32'd0);
        check("rst_count", instr_count, 0);
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = '0;
        m_err = 1'b0;
        m_alu = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [5:0]  op;
        int          r;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();

        send(32'h014B4820, 1'b0, 0);
        send(32'h8D090004, 1'b0, 0);
        send(32'hAD090004, 1'b0, 0);
        send(32'h110A0003, 1'b1, 0);
        send(32'h110A0003, 1'b0, 0);
        send(32'h01400020, 1'b0, 0);
        send(32'hFC000000, 1'b0, 0);
        send(32'h016C6822, 1'b0, 1);
        drain();
        check("error_sticky", error, m_err);
        check("count_after_plan", instr_count, m_cnt);

        // Reset during EXECUTE of an R-type abandons it with no write
        send(32'h014B4820, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        check("alu_op_in_execute", alu_op, 2'b10);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();
        repeat (4) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            send(32'h014B4820 | (32'(i % 31 + 1) << 11), 1'b0, 0);
        end
        drain();
        check("count_wrap", instr_count, m_cnt);
        check("count_wrap_value", instr_count, 1);

        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do op = 6'($urandom_range(0, 63));
                while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04);
            end else if (r < 8)  op = 6'h00;
            else if (r < 12)     op = 6'h23;
            else if (r < 16)     op = 6'h2B;
            else                 op = 6'h04;
            w[31:26] = op;
            if ($urandom_range(0, 5) == 0) begin
                w[15:11] = 5'd0;
                w[20:16] = 5'd0;
            end
            send(w, 1'($urandom_range(0, 1)), 0);
        end
        drain();
        check("final_count", instr_count, m_cnt);
        check("final_error", error, m_err);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
